// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select, load-use / scoreboard / stall-only RAW hazard detection,
// long-latency scoreboard and saturating performance counters for a 5-stage pipeline.
module fwd_hazard_unit #(
    parameter int NUM_SRC = 2,
    parameter int AW      = 5,
    parameter int FWD_EN  = 1,
    parameter int CNT_W   = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_SRC*AW-1:0]   ex_src_addr,
    input  logic [NUM_SRC-1:0]      ex_src_used,
    input  logic [NUM_SRC*AW-1:0]   id_src_addr,
    input  logic [NUM_SRC-1:0]      id_src_used,
    input  logic [AW-1:0]           id_ex_rd,
    input  logic                    id_ex_reg_write,
    input  logic                    id_ex_mem_read,
    input  logic [AW-1:0]           ex_mem_rd,
    input  logic                    ex_mem_reg_write,
    input  logic [AW-1:0]           mem_wb_rd,
    input  logic                    mem_wb_reg_write,
    input  logic                    lat_issue_valid,
    input  logic [AW-1:0]           lat_issue_rd,
    input  logic                    lat_done_valid,
    input  logic [AW-1:0]           lat_done_rd,
    output logic [2*NUM_SRC-1:0]    fwd_sel,
    output logic                    stall,
    output logic [1:0]              stall_cause,
    output logic [AW:0]             sb_pending,
    output logic [CNT_W-1:0]        stall_cycles,
    output logic [CNT_W-1:0]        lu_events
);
    localparam int NREG = 2**AW;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_LU   = 2'b01;
    localparam logic [1:0] CAUSE_SB   = 2'b10;
    localparam logic [1:0] CAUSE_RAW  = 2'b11;

    logic [NREG-1:0] sb_p1;
    logic [NREG-1:0] sb_nxt;
    logic [1:0]      cause_p1;
    logic            lu_haz;
    logic            sb_haz;
    logic            raw_haz;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
        logic [AW:0] n;
        n = '0;
        for (int k = 0; k < NREG; k++) begin
            n = n + {{AW{1'b0}}, v[k]};
        end
        return n;
    endfunction

    // EX stage: operand bypass select, EX/MEM has priority over MEM/WB
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (FWD_EN != 0 && ex_src_used[i] && ex_src_addr[i*AW +: AW] != '0) begin
                if (ex_mem_reg_write && ex_mem_rd == ex_src_addr[i*AW +: AW]) begin
                    fwd_sel[2*i +: 2] = 2'b01;
                end else if (mem_wb_reg_write && mem_wb_rd == ex_src_addr[i*AW +: AW]) begin
                    fwd_sel[2*i +: 2] = 2'b10;
                end
            end
        end
    end

    // ID stage: hazard detection against EX, MEM and the scoreboard
    always_comb begin
        lu_haz  = 1'b0;
        sb_haz  = 1'b0;
        raw_haz = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_src_used[i]) begin
                if (id_ex_mem_read && id_ex_reg_write && id_ex_rd != '0 &&
                    id_ex_rd == id_src_addr[i*AW +: AW]) begin
                    lu_haz = 1'b1;
                end
                if (id_src_addr[i*AW +: AW] != '0) begin
                    if (sb_p1[id_src_addr[i*AW +: AW]]) begin
                        sb_haz = 1'b1;
                    end
                    // Without bypass paths, any in-flight producer in EX or MEM must drain first
                    if (FWD_EN == 0 &&
                        ((id_ex_reg_write && id_ex_rd == id_src_addr[i*AW +: AW]) ||
                         (ex_mem_reg_write && ex_mem_rd == id_src_addr[i*AW +: AW]))) begin
                        raw_haz = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        stall_cause = CAUSE_NONE;
        if (sb_haz) begin
            stall_cause = CAUSE_SB;
        end else if (lu_haz) begin
            stall_cause = CAUSE_LU;
        end else if (raw_haz) begin
            stall_cause = CAUSE_RAW;
        end
    end

    assign stall = sb_haz | lu_haz | raw_haz;

    // Issue is applied after done so a same-register set/clear leaves the bit set
    always_comb begin
        sb_nxt = sb_p1;
        if (lat_done_valid) begin
            sb_nxt[lat_done_rd] = 1'b0;
        end
        if (lat_issue_valid && !stall) begin
            sb_nxt[lat_issue_rd] = 1'b1;
        end
        sb_nxt[0] = 1'b0;
    end

    // Registered state: scoreboard, occupancy, counters, previous cause
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_p1        <= '0;
            sb_pending   <= '0;
            stall_cycles <= '0;
            lu_events    <= '0;
            cause_p1     <= CAUSE_NONE;
        end else begin
            sb_p1      <= sb_nxt;
            sb_pending <= popcount(sb_nxt);
            if (stall) begin
                stall_cycles <= sat_inc(stall_cycles);
            end
            if (stall_cause == CAUSE_LU && cause_p1 != CAUSE_LU) begin
                lu_events <= sat_inc(lu_events);
            end
            cause_p1 <= stall_cause;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: a forwarding DUT (CNT_W=32) and a stall-only DUT (CNT_W=4)
// share stimulus and are compared every cycle against a behavioural model.
module tb_fwd_hazard_unit;
    localparam int NS   = 2;
    localparam int AW   = 5;
    localparam int CW_A = 32;
    localparam int CW_B = 4;

    logic clk = 1'b0;
    logic reset;
    logic [NS*AW-1:0] ex_src_addr, id_src_addr;
    logic [NS-1:0]    ex_src_used, id_src_used;
    logic [AW-1:0]    id_ex_rd, ex_mem_rd, mem_wb_rd, lat_issue_rd, lat_done_rd;
    logic id_ex_reg_write, id_ex_mem_read, ex_mem_reg_write, mem_wb_reg_write;
    logic lat_issue_valid, lat_done_valid;

    logic [2*NS-1:0] fwd_a, fwd_b;
    logic            stall_a, stall_b;
    logic [1:0]      cause_a, cause_b;
    logic [AW:0]     pend_a, pend_b;
    logic [CW_A-1:0] sc_a, lu_a;
    logic [CW_B-1:0] sc_b, lu_b;

    int checks = 0;
    int failures = 0;

    bit     sb_m [2][2**AW];
    longint m_sc [2];
    longint m_lu [2];
    int     m_prev [2];
    longint cmax [2];
    int     e_fwd [2];
    int     e_cause [2];
    bit     e_stall [2];

    always #5 clk = ~clk;

    fwd_hazard_unit #(.NUM_SRC(NS), .AW(AW), .FWD_EN(1), .CNT_W(CW_A)) dut_a (
        .clk(clk), .reset(reset),
        .ex_src_addr(ex_src_addr), .ex_src_used(ex_src_used),
        .id_src_addr(id_src_addr), .id_src_used(id_src_used),
        .id_ex_rd(id_ex_rd), .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
        .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
        .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write),
        .lat_issue_valid(lat_issue_valid), .lat_issue_rd(lat_issue_rd),
        .lat_done_valid(lat_done_valid), .lat_done_rd(lat_done_rd),
        .fwd_sel(fwd_a), .stall(stall_a), .stall_cause(cause_a), .sb_pending(pend_a),
        .stall_cycles(sc_a), .lu_events(lu_a)
    );

    fwd_hazard_unit #(.NUM_SRC(NS), .AW(AW), .FWD_EN(0), .CNT_W(CW_B)) dut_b (
        .clk(clk), .reset(reset),
        .ex_src_addr(ex_src_addr), .ex_src_used(ex_src_used),
        .id_src_addr(id_src_addr), .id_src_used(id_src_used),
        .id_ex_rd(id_ex_rd), .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
        .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
        .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write),
        .lat_issue_valid(lat_issue_valid), .lat_issue_rd(lat_issue_rd),
        .lat_done_valid(lat_done_valid), .lat_done_rd(lat_done_rd),
        .fwd_sel(fwd_b), .stall(stall_b), .stall_cause(cause_b), .sb_pending(pend_b),
        .stall_cycles(sc_b), .lu_events(lu_b)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int src_of(input logic [NS*AW-1:0] v, input int i);
        return int'(v[i*AW +: AW]);
    endfunction

    function automatic int pend_m(input int d);
        int n = 0;
        for (int r = 0; r < 2**AW; r++) n += int'(sb_m[d][r]);
        return n;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 2**AW; r++) sb_m[d][r] = 1'b0;
            m_sc[d] = 0;
            m_lu[d] = 0;
            m_prev[d] = 0;
        end
    endtask

    // d=0: forwarding DUT, d=1: stall-only DUT
    task automatic model_eval(input int d);
        bit fen = (d == 0);
        bit lu = 0, sbh = 0, raw = 0;
        int a, code;
        e_fwd[d] = 0;
        for (int i = 0; i < NS; i++) begin
            a = src_of(ex_src_addr, i);
            code = 0;
            if (fen && ex_src_used[i] && a != 0) begin
                if (ex_mem_reg_write && int'(ex_mem_rd) == a) code = 1;
                else if (mem_wb_reg_write && int'(mem_wb_rd) == a) code = 2;
            end
            e_fwd[d] |= code << (2*i);
        end
        for (int i = 0; i < NS; i++) begin
            a = src_of(id_src_addr, i);
            if (!id_src_used[i]) continue;
            if (id_ex_mem_read && id_ex_reg_write && id_ex_rd != 0 && int'(id_ex_rd) == a) lu = 1;
            if (a != 0 && sb_m[d][a]) sbh = 1;
            if (!fen && a != 0 && ((id_ex_reg_write && int'(id_ex_rd) == a) ||
                                   (ex_mem_reg_write && int'(ex_mem_rd) == a))) raw = 1;
        end
        e_cause[d] = sbh ? 2 : lu ? 1 : raw ? 3 : 0;
        e_stall[d] = (e_cause[d] != 0);
    endtask

    task automatic model_update(input int d);
        if (lat_done_valid) sb_m[d][lat_done_rd] = 1'b0;
        if (lat_issue_valid && !e_stall[d] && lat_issue_rd != 0) sb_m[d][lat_issue_rd] = 1'b1;
        if (e_stall[d] && m_sc[d] < cmax[d]) m_sc[d]++;
        if (e_cause[d] == 1 && m_prev[d] != 1 && m_lu[d] < cmax[d]) m_lu[d]++;
        m_prev[d] = e_cause[d];
    endtask

    task automatic check_now(input string tag);
        #1;
        model_eval(0);
        model_eval(1);
        chk({tag, ".fwd_a"},   fwd_a,   e_fwd[0]);
        chk({tag, ".stall_a"}, stall_a, e_stall[0]);
        chk({tag, ".cause_a"}, cause_a, e_cause[0]);
        chk({tag, ".pend_a"},  pend_a,  pend_m(0));
        chk({tag, ".sc_a"},    sc_a,    m_sc[0]);
        chk({tag, ".lu_a"},    lu_a,    m_lu[0]);
        chk({tag, ".fwd_b"},   fwd_b,   e_fwd[1]);
        chk({tag, ".stall_b"}, stall_b, e_stall[1]);
        chk({tag, ".cause_b"}, cause_b, e_cause[1]);
        chk({tag, ".pend_b"},  pend_b,  pend_m(1));
        chk({tag, ".sc_b"},    sc_b,    m_sc[1]);
        chk({tag, ".lu_b"},    lu_b,    m_lu[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            model_update(0);
            model_update(1);
        end
        @(negedge clk);
    endtask

    task automatic step(input string tag);
        check_now(tag);
        tick();
    endtask

    task automatic idle();
        ex_src_addr = '0; ex_src_used = '0; id_src_addr = '0; id_src_used = '0;
        id_ex_rd = '0; id_ex_reg_write = 0; id_ex_mem_read = 0;
        ex_mem_rd = '0; ex_mem_reg_write = 0; mem_wb_rd = '0; mem_wb_reg_write = 0;
        lat_issue_valid = 0; lat_issue_rd = '0; lat_done_valid = 0; lat_done_rd = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_clear();
        check_now("rst");
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [AW-1:0] ra();
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin
        cmax[0] = 64'hFFFF_FFFF;
        cmax[1] = 15;
        idle();
        do_reset();
        chk("reset.sc_a", sc_a, 0);
        chk("reset.pend_a", pend_a, 0);

        // EX/MEM beats MEM/WB on the same register
        ex_src_addr = {5'd5, 5'd5}; ex_src_used = 2'b11;
        ex_mem_rd = 5; ex_mem_reg_write = 1; mem_wb_rd = 5; mem_wb_reg_write = 1;
        check_now("fwd_pri");
        chk("fwd_pri.lit_a", fwd_a, 4'b0101);
        chk("fwd_pri.lit_b", fwd_b, 0);
        tick();

        // r0 never forwarded
        ex_src_addr = {5'd4, 5'd0}; ex_mem_rd = 0; mem_wb_rd = 4;
        check_now("fwd_r0");
        chk("fwd_r0.lit_a", fwd_a, 4'b1000);
        tick();

        // Load-use then bubble
        idle();
        do_reset();
        id_src_addr = {5'd7, 5'd0}; id_src_used = 2'b10;
        id_ex_rd = 7; id_ex_mem_read = 1; id_ex_reg_write = 1;
        check_now("lu");
        chk("lu.stall_lit", stall_a, 1);
        chk("lu.cause_lit", cause_a, 1);
        chk("lu.cnt_lit", lu_a, 0);
        tick();
        id_ex_rd = 0; id_ex_mem_read = 0; id_ex_reg_write = 0;
        check_now("lu_bub");
        chk("lu_bub.stall_lit", stall_a, 0);
        chk("lu_bub.lu_lit", lu_a, 1);
        chk("lu_bub.sc_lit", sc_a, 1);
        tick();

        // Scoreboard sequence on r9
        idle();
        do_reset();
        lat_issue_valid = 1; lat_issue_rd = 9;
        step("sb_c0");
        idle();
        step("sb_c1");
        step("sb_c2");
        id_src_addr = {5'd0, 5'd9}; id_src_used = 2'b01;
        check_now("sb_c3");
        chk("sb_c3.stall_lit", stall_a, 1);
        chk("sb_c3.cause_lit", cause_a, 2);
        chk("sb_c3.pend_lit", pend_a, 1);
        tick();
        lat_done_valid = 1; lat_done_rd = 9;
        step("sb_c4");
        lat_done_valid = 0;
        check_now("sb_c5");
        chk("sb_c5.stall_lit", stall_a, 0);
        chk("sb_c5.pend_lit", pend_a, 0);
        tick();

        // Same-cycle issue/done on a busy register, then redundant done
        idle();
        lat_issue_valid = 1; lat_issue_rd = 3;
        step("sd_set");
        lat_done_valid = 1; lat_done_rd = 3;
        check_now("sd_both");
        chk("sd_both.pend_lit", pend_a, 1);
        tick();
        idle();
        check_now("sd_after");
        chk("sd_after.pend_lit", pend_a, 1);
        tick();
        lat_done_valid = 1; lat_done_rd = 3;
        step("sd_done");
        check_now("sd_noop");
        chk("sd_noop.pend_lit", pend_a, 0);
        tick();

        // Saturation with CNT_W=4 and reset in the middle of a stall
        idle();
        do_reset();
        lat_issue_valid = 1; lat_issue_rd = 12;
        step("sat_iss");
        idle();
        id_src_addr = {5'd7, 5'd12}; id_src_used = 2'b11;
        id_ex_rd = 7; id_ex_mem_read = 1; id_ex_reg_write = 1;
        for (int k = 0; k < 20; k++) step("sat_hold");
        check_now("sat_end");
        chk("sat_end.sc_b_lit", sc_b, 15);
        chk("sat_end.sc_a_lit", sc_a, 20);
        chk("sat_end.cause_lit", cause_a, 2);
        tick();
        check_now("sat_keep");
        chk("sat_keep.sc_b_lit", sc_b, 15);
        reset = 1'b1;
        model_clear();
        check_now("mid_rst");
        chk("mid_rst.sc_a_lit", sc_a, 0);
        chk("mid_rst.sc_b_lit", sc_b, 0);
        chk("mid_rst.lu_a_lit", lu_a, 0);
        chk("mid_rst.pend_a_lit", pend_a, 0);
        chk("mid_rst.cause_lit", cause_a, 1);
        tick();
        reset = 1'b0;

        // Randomized traffic over a small register window to provoke hits
        for (int n = 0; n < 400; n++) begin
            ex_src_addr = {ra(), ra()};
            id_src_addr = {ra(), ra()};
            ex_src_used = 2'($urandom);
            id_src_used = 2'($urandom);
            id_ex_rd = ra(); ex_mem_rd = ra(); mem_wb_rd = ra();
            id_ex_reg_write = 1'($urandom);
            id_ex_mem_read = ($urandom_range(0, 2) == 0);
            ex_mem_reg_write = 1'($urandom);
            mem_wb_reg_write = 1'($urandom);
            lat_issue_valid = ($urandom_range(0, 2) == 0);
            lat_issue_rd = ra();
            lat_done_valid = ($urandom_range(0, 1) == 0);
            lat_done_rd = ra();
            if (n == 200) do_reset();
            else step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter NUM_SRC, default 2, SHALL set the number of source operands per instruction.
REQ-002 Parameter AW, default 5, SHALL set the register-address width; the register count is 2**AW.
REQ-003 Parameter FWD_EN, default 1: 1 = forwarding enabled; 0 = stall-only mode.
REQ-004 Parameter CNT_W, default 32, SHALL set the width of the performance counters.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 ex_src_addr  in  NUM_SRC*AW  source register addresses of the instruction in EX; source i occupies bits [i*AW +: AW].
REQ-008 ex_src_used  in  NUM_SRC  per-source valid for the instruction in EX.
REQ-009 id_src_addr  in  NUM_SRC*AW  source register addresses of the instruction in ID, packed as in REQ-007.
REQ-010 id_src_used  in  NUM_SRC  per-source valid for the instruction in ID.
REQ-011 id_ex_rd / id_ex_reg_write / id_ex_mem_read  in  AW/1/1  destination, write enable and load flag of the instruction in EX.
REQ-012 ex_mem_rd / ex_mem_reg_write  in  AW/1  destination and write enable of the instruction in MEM.
REQ-013 mem_wb_rd / mem_wb_reg_write  in  AW/1  destination and write enable of the instruction in WB.
REQ-014 lat_issue_valid / lat_issue_rd  in  1/AW  a long-latency op (mul/div) leaves ID targeting rd.
REQ-015 lat_done_valid / lat_done_rd  in  1/AW  a long-latency op writes back rd.
REQ-016 fwd_sel  out  2*NUM_SRC  per EX source: 00 = regfile, 01 = EX/MEM, 10 = MEM/WB, 11 = never driven.
REQ-017 stall  out  1  hold PC and IF/ID and insert a bubble into ID/EX.
REQ-018 stall_cause  out  2  00 = none, 01 = load-use, 10 = scoreboard, 11 = RAW in stall-only mode.
REQ-019 sb_pending  out  AW+1  number of registers currently marked busy in the scoreboard.
REQ-020 stall_cycles / lu_events  out  CNT_W each  performance counters.

Function
REQ-021 Forwarding SHALL be combinational. For each source i with ex_src_used[i]=1 and address !=0, fwd_sel SHALL be:
- 01 if ex_mem_reg_write is set and ex_mem_rd matches;
- else 10 if mem_wb_reg_write is set and mem_wb_rd matches;
- else 00.
REQ-022 A source with address 0 or used=0 SHALL get fwd_sel=00. With FWD_EN=0, every fwd_sel SHALL be 00.
REQ-023 Load-use hazard: id_ex_mem_read=1, id_ex_reg_write=1, id_ex_rd!=0, and id_ex_rd equals some used ID source.
REQ-024 Scoreboard hazard: some used, nonzero ID source whose scoreboard bit is set.
REQ-025 Stall-only RAW hazard (FWD_EN=0 only): some used, nonzero ID source equals id_ex_rd with id_ex_reg_write=1, or equals ex_mem_rd with ex_mem_reg_write=1. MEM/WB is not checked because the regfile writes before it is read.
REQ-026 stall SHALL be the combinational OR of the enabled hazards. stall_cause SHALL report one cause with priority scoreboard > load-use > RAW.
REQ-027 Scoreboard: one register bit per address, 2**AW bits; bit 0 is never set.
- lat_issue_valid=1 with stall=0 sets bit[lat_issue_rd] at the next edge.
- lat_issue_valid=1 with stall=1 is ignored.
REQ-028 lat_done_valid SHALL clear bit[lat_done_rd] at the next edge. If issue and done target the same rd in the same cycle, the set wins.
REQ-029 A done for a register whose bit is clear SHALL be a no-op.
REQ-030 sb_pending SHALL be registered and equal the popcount of the scoreboard after each edge.
REQ-031 Counter updates at each edge:
- stall_cycles SHALL increment when stall=1.
- lu_events SHALL increment on a cycle where the cause is load-use and the previous cycle's cause was not load-use; this requires a registered copy of the previous cause.
REQ-032 Both counters SHALL saturate at all-ones and never wrap.
REQ-033 Latency: forwarding and stall are 0-cycle combinational; scoreboard and counter effects are visible 1 cycle after the triggering edge.

Reset
REQ-034 reset=1 SHALL asynchronously clear the scoreboard, sb_pending, stall_cycles, lu_events and the previous-cause register to 0.
REQ-035 Reset mid-stall SHALL drop any scoreboard-caused stall immediately; combinational outputs follow their inputs during reset.
REQ-036 Release of reset SHALL need no extra cycle; the first edge after deassertion is a normal update.

Verification
REQ-037 ex_src_addr={5,5}, used=11, ex_mem_rd=5/we=1, mem_wb_rd=5/we=1 -> fwd_sel=0101 (EX/MEM priority).
REQ-038 ex src0=0 matching ex_mem_rd=0/we=1 -> fwd_sel[1:0]=00.
REQ-039 id src1=7, id_ex_rd=7 load -> stall=1 and cause=01 for exactly that cycle; with a bubble in the next cycle stall=0. lu_events goes 0->1 and stall_cycles goes 0->1.
REQ-040 Sequence:
- cycle 0: lat_issue rd=9;
- cycle 3: ID src=9 -> stall=1, cause=10, sb_pending=1;
- cycle 4: lat_done rd=9 -> stall drops in cycle 5, sb_pending=0.
REQ-041 Same cycle lat_issue rd=3 and lat_done rd=3 with bit[3]=1 -> bit[3] remains 1, sb_pending unchanged.
REQ-042 CNT_W=4, stall held 20 cycles -> stall_cycles=15 and holds. Assert reset mid-stall -> all counters and sb_pending read 0 before the next edge.
